// File: rtl/reloj_tiempo_pkg.sv
// Shared clock definitions: mode-state encodings and the field limits used by the counters and the display decoders.
// The alarm states are reached only when RELOJ_ALARMA_EN is defined.
package reloj_tiempo_pkg;

  localparam int HORA_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int SEG_MAX  = 59;

  localparam int HORA_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEG_W  = 6;
  localparam int MODO_W = 3;

  typedef enum logic [MODO_W-1:0] {
    NORMAL       = 3'd0,
    SET_HORA     = 3'd1,
    SET_MIN      = 3'd2,
    SET_ALM_HORA = 3'd3,
    SET_ALM_MIN  = 3'd4
  } modo_t;

endpackage

// File: rtl/reloj_tiempo_contador_modn.sv
// Modulo-(MAX+1) counter that supplies one time field. It is registered, so valor updates on the edge after inc.
// carry is combinational from inc; clr takes priority over inc, and an out-of-range value recovers to 0.
module contador_modn #(
  parameter int MAX   = 59,
  parameter int WIDTH = 6,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] valor,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  assign carry = inc && !clr && (valor >= MAX_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valor <= INIT_V;
    end else if (clr) begin
      valor <= '0;
    end else if (inc) begin
      valor <= (valor >= MAX_V) ? '0 : valor + WIDTH'(1);
    end else if (valor > MAX_V) begin
      valor <= '0;
    end
  end

endmodule

// File: rtl/reloj_tiempo.sv
// 24-hour clock with a set-mode FSM; its outputs are registered and lag tick_1hz and button pulses by one cycle.
// There is no backpressure. Defining RELOJ_ALARMA_EN adds the alarm set states, the alarm registers and alarma.
module reloj_tiempo
  import reloj_tiempo_pkg::*;
#(
  parameter int HORA_INI = 0,
  parameter int MIN_INI  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_1hz,
  input  logic              btn_modo,
  input  logic              btn_inc,
  output logic [HORA_W-1:0] hora,
  output logic [MIN_W-1:0]  minuto,
  output logic [SEG_W-1:0]  segundo,
  output logic [MODO_W-1:0] modo,
  output logic              fin_dia,
  output logic              alarma
);

  modo_t state, state_nxt;

  logic en_normal, seg_clr, set_hora_inc, set_min_inc;
  logic seg_inc, min_inc, hora_inc;
  logic seg_carry, min_carry, hora_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NORMAL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = NORMAL;
    case (state)
      NORMAL:       state_nxt = btn_modo ? SET_HORA : NORMAL;
      SET_HORA:     state_nxt = btn_modo ? SET_MIN : SET_HORA;
`ifdef RELOJ_ALARMA_EN
      SET_MIN:      state_nxt = btn_modo ? SET_ALM_HORA : SET_MIN;
      SET_ALM_HORA: state_nxt = btn_modo ? SET_ALM_MIN : SET_ALM_HORA;
      SET_ALM_MIN:  state_nxt = btn_modo ? NORMAL : SET_ALM_MIN;
`else
      SET_MIN:      state_nxt = btn_modo ? NORMAL : SET_MIN;
`endif
      default:      state_nxt = NORMAL;
    endcase
  end

`ifdef RELOJ_ALARMA_EN
  logic set_alm_hora_inc, set_alm_min_inc;
`endif

  // A button press in the same cycle as btn_modo belongs to the mode change and is dropped.
  always_comb begin
    en_normal    = 1'b0;
    seg_clr      = 1'b0;
    set_hora_inc = 1'b0;
    set_min_inc  = 1'b0;
`ifdef RELOJ_ALARMA_EN
    set_alm_hora_inc = 1'b0;
    set_alm_min_inc  = 1'b0;
`endif
    case (state)
      NORMAL: begin
        en_normal = 1'b1;
        seg_clr   = btn_modo;
      end
      SET_HORA: set_hora_inc = btn_inc && !btn_modo;
      SET_MIN:  set_min_inc  = btn_inc && !btn_modo;
`ifdef RELOJ_ALARMA_EN
      SET_ALM_HORA: set_alm_hora_inc = btn_inc && !btn_modo;
      SET_ALM_MIN:  set_alm_min_inc  = btn_inc && !btn_modo;
`endif
      default: ;
    endcase
  end

  assign seg_inc  = en_normal && tick_1hz && !btn_modo;
  assign min_inc  = en_normal ? seg_carry : set_min_inc;
  assign hora_inc = en_normal ? min_carry : set_hora_inc;
  assign modo     = state;

  contador_modn #(.MAX(SEG_MAX), .WIDTH(SEG_W), .INIT(0)) u_seg (
    .clk(clk), .rst_n(rst_n), .inc(seg_inc), .clr(seg_clr), .valor(segundo), .carry(seg_carry)
  );

  contador_modn #(.MAX(MIN_MAX), .WIDTH(MIN_W), .INIT(MIN_INI)) u_min (
    .clk(clk), .rst_n(rst_n), .inc(min_inc), .clr(1'b0), .valor(minuto), .carry(min_carry)
  );

  contador_modn #(.MAX(HORA_MAX), .WIDTH(HORA_W), .INIT(HORA_INI)) u_hora (
    .clk(clk), .rst_n(rst_n), .inc(hora_inc), .clr(1'b0), .valor(hora), .carry(hora_carry)
  );

  // Setting hour 23 -> 0 also raises hora_carry, so only a running rollover counts as end of day.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fin_dia <= 1'b0;
    else        fin_dia <= en_normal && hora_carry;
  end

`ifdef RELOJ_ALARMA_EN
  logic [HORA_W-1:0] alm_hora;
  logic [MIN_W-1:0]  alm_min;
  logic              alm_hora_unused_carry, alm_min_unused_carry;

  contador_modn #(.MAX(HORA_MAX), .WIDTH(HORA_W), .INIT(0)) u_alm_hora (
    .clk(clk), .rst_n(rst_n), .inc(set_alm_hora_inc), .clr(1'b0),
    .valor(alm_hora), .carry(alm_hora_unused_carry)
  );

  contador_modn #(.MAX(MIN_MAX), .WIDTH(MIN_W), .INIT(0)) u_alm_min (
    .clk(clk), .rst_n(rst_n), .inc(set_alm_min_inc), .clr(1'b0),
    .valor(alm_min), .carry(alm_min_unused_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         alarma <= 1'b0;
    else if (btn_modo)                                  alarma <= 1'b0;
    else if (en_normal && seg_carry)                    alarma <= 1'b0;
    else if (en_normal && hora == alm_hora && minuto == alm_min) alarma <= 1'b1;
  end
`else
  assign alarma = 1'b0;
`endif

endmodule
